// File: rtl/hdmi_channel_decode.sv
// hdmi_channel_decode: single TMDS channel receive decoder.
// Finds the 10-bit word boundary in a raw deserialized stream by hunting
// for runs of TMDS control tokens at each of the ten bit offsets, then
// decodes data words (o_de=1) and control tokens ({C1,C0} on o_c).
// Pipeline: previous-word register + offset window -> w1 register ->
// output register.
// Optional build macro HDMI_DEC_GLITCH_CNT_EN adds o_glitch_cnt, a
// saturating count of isolated non-token words inside control periods.

module hdmi_channel_decode #(
   parameter int CTRL_RUN_LEN = 16,
   parameter int DWELL_CYCLES = 4096,
   parameter int LOSS_TIMEOUT = 8192
) (
   input  logic        i_p_clk,
   input  logic        i_reset,
   input  logic [9:0]  i_tmds_word,
   output logic [7:0]  o_data,
   output logic [1:0]  o_c,
   output logic        o_de,
   output logic        o_locked,
   output logic [3:0]  o_offset
`ifdef HDMI_DEC_GLITCH_CNT_EN
   ,
   output logic [15:0] o_glitch_cnt
`endif
);

   localparam int RUN_W   = $clog2(CTRL_RUN_LEN + 1);
   localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
   localparam int LOSS_W  = $clog2(LOSS_TIMEOUT + 1);

   localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(CTRL_RUN_LEN - 1);
   localparam logic [RUN_W-1:0]   RUN_MAX    = '1;
   localparam logic [RUN_W-1:0]   RUN_ONE    = RUN_W'(1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX  = '1;
   localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
   localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_TIMEOUT - 1);
   localparam logic [LOSS_W-1:0]  LOSS_MAX   = '1;
   localparam logic [LOSS_W-1:0]  LOSS_ONE   = LOSS_W'(1);

   localparam logic [0:0] ST_SEARCH = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // Returns {is_token, C1, C0} for a candidate aligned word.
   function automatic logic [2:0] f_token(input logic [9:0] w);
      logic [2:0] r;
      case (w)
         10'b1101010100: r = 3'b1_00;
         10'b0010101011: r = 3'b1_01;
         10'b0101010100: r = 3'b1_10;
         10'b1010101011: r = 3'b1_11;
         default:        r = 3'b0_00;
      endcase
      return r;
   endfunction

   // TMDS data decode: undo optional inversion, then undo XOR/XNOR chain.
   function automatic logic [7:0] f_decode(input logic [9:0] w);
      logic [7:0] t;
      logic [7:0] d;
      t    = w[9] ? ~w[7:0] : w[7:0];
      d[0] = t[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = w[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
      end
      return d;
   endfunction

   logic [9:0]         r_prev;
   logic [9:0]         r_w1;
   logic [0:0]         r_state;
   logic [3:0]         r_offset;
   logic [RUN_W-1:0]   r_run;
   logic [DWELL_W-1:0] r_dwell;
   logic [LOSS_W-1:0]  r_loss;
   logic               r_settle;
   logic [7:0]         r_data;
   logic [1:0]         r_c;
   logic               r_de;
   logic               r_locked;

   logic [19:0]        w_cat;
   logic [9:0]         w_window;
   logic [2:0]         w_tok_info;
   logic               w_tok_is;
   logic [1:0]         w_tok_c;
   logic               w_tok_eval;
   logic               w_lock_hit;
   logic [7:0]         w_dec;

   logic [0:0]         w_state_nx;
   logic [3:0]         w_offset_nx;
   logic [RUN_W-1:0]   w_run_nx;
   logic [DWELL_W-1:0] w_dwell_nx;
   logic [LOSS_W-1:0]  w_loss_nx;
   logic               w_settle_nx;
   logic [7:0]         w_data_nx;
   logic [1:0]         w_c_nx;
   logic               w_de_nx;

   // Bit 0 of the stream is the earliest bit, so the older word sits low.
   assign w_cat      = {i_tmds_word, r_prev};
   assign w_window   = w_cat[{1'b0, r_offset} +: 10];
   assign w_tok_info = f_token(r_w1);
   assign w_tok_is   = w_tok_info[2];
   assign w_tok_c    = w_tok_info[1:0];
   // Right after an offset step, w1 still holds a window cut at the old offset.
   assign w_tok_eval = w_tok_is & ~r_settle;
   assign w_lock_hit = w_tok_eval & (r_run == RUN_LAST);
   assign w_dec      = f_decode(r_w1);

   // Alignment search / lock tracking and next output values.
   always_comb begin
      w_state_nx  = r_state;
      w_offset_nx = r_offset;
      w_run_nx    = r_run;
      w_dwell_nx  = r_dwell;
      w_loss_nx   = r_loss;
      w_settle_nx = 1'b0;
      w_data_nx   = r_data;
      w_c_nx      = r_c;
      w_de_nx     = r_de;
      case (r_state)
         ST_SEARCH: begin
            w_data_nx = 8'd0;
            w_c_nx    = 2'd0;
            w_de_nx   = 1'b0;
            if (w_lock_hit) begin
               // Lock beats a simultaneous dwell expiry: offset stays put.
               w_state_nx = ST_LOCKED;
               w_run_nx   = '0;
               w_dwell_nx = '0;
               w_loss_nx  = '0;
               w_c_nx     = w_tok_c;
            end else if (r_dwell == DWELL_LAST) begin
               w_offset_nx = (r_offset == 4'd9) ? 4'd0 : (r_offset + 4'd1);
               w_dwell_nx  = '0;
               w_run_nx    = '0;
               w_settle_nx = 1'b1;
            end else begin
               w_dwell_nx = (r_dwell == DWELL_MAX) ? r_dwell : (r_dwell + DWELL_ONE);
               if (w_tok_eval) begin
                  w_run_nx = (r_run == RUN_MAX) ? r_run : (r_run + RUN_ONE);
               end else begin
                  w_run_nx = '0;
               end
            end
         end
         ST_LOCKED: begin
            w_run_nx   = '0;
            w_dwell_nx = '0;
            if (w_tok_is) begin
               w_loss_nx = '0;
               w_de_nx   = 1'b0;
               w_c_nx    = w_tok_c;
            end else if (r_loss == LOSS_LAST) begin
               // Drop lock; offset kept so the hunt restarts where it last worked.
               w_state_nx = ST_SEARCH;
               w_loss_nx  = '0;
               w_data_nx  = 8'd0;
               w_c_nx     = 2'd0;
               w_de_nx    = 1'b0;
            end else begin
               w_loss_nx = (r_loss == LOSS_MAX) ? r_loss : (r_loss + LOSS_ONE);
               w_de_nx   = 1'b1;
               w_data_nx = w_dec;
            end
         end
         default: begin
            w_state_nx = ST_SEARCH;
            w_run_nx   = '0;
            w_dwell_nx = '0;
            w_loss_nx  = '0;
            w_data_nx  = 8'd0;
            w_c_nx     = 2'd0;
            w_de_nx    = 1'b0;
         end
      endcase
   end

   // Pipeline, FSM and output registers.
   always_ff @(posedge i_p_clk) begin
      if (i_reset) begin
         r_prev   <= 10'd0;
         r_w1     <= 10'd0;
         r_state  <= ST_SEARCH;
         r_offset <= 4'd0;
         r_run    <= '0;
         r_dwell  <= '0;
         r_loss   <= '0;
         r_settle <= 1'b0;
         r_data   <= 8'd0;
         r_c      <= 2'd0;
         r_de     <= 1'b0;
         r_locked <= 1'b0;
      end else begin
         r_prev   <= i_tmds_word;
         r_w1     <= w_window;
         r_state  <= w_state_nx;
         r_offset <= w_offset_nx;
         r_run    <= w_run_nx;
         r_dwell  <= w_dwell_nx;
         r_loss   <= w_loss_nx;
         r_settle <= w_settle_nx;
         r_data   <= w_data_nx;
         r_c      <= w_c_nx;
         r_de     <= w_de_nx;
         r_locked <= (w_state_nx == ST_LOCKED);
      end
   end

   assign o_data   = r_data;
   assign o_c      = r_c;
   assign o_de     = r_de;
   assign o_locked = r_locked;
   assign o_offset = r_offset;

`ifdef HDMI_DEC_GLITCH_CNT_EN
   logic        r_tok_h1;
   logic        r_tok_h2;
   logic [15:0] r_glitch;
   logic        w_glitch_hit;
   logic        w_enter_search;

   // An isolated glitch is token / non-token / token seen in consecutive w1.
   assign w_glitch_hit   = (r_state == ST_LOCKED) & w_tok_is & ~r_tok_h1 & r_tok_h2;
   assign w_enter_search = (r_state == ST_LOCKED) & (w_state_nx == ST_SEARCH);

   // Token history and saturating glitch counter.
   always_ff @(posedge i_p_clk) begin
      if (i_reset) begin
         r_tok_h1 <= 1'b0;
         r_tok_h2 <= 1'b0;
         r_glitch <= 16'd0;
      end else begin
         r_tok_h1 <= w_tok_is;
         r_tok_h2 <= r_tok_h1;
         if (w_enter_search) begin
            r_glitch <= 16'd0;
         end else if (w_glitch_hit && (r_glitch != 16'hFFFF)) begin
            r_glitch <= r_glitch + 16'd1;
         end else begin
            r_glitch <= r_glitch;
         end
      end
   end

   assign o_glitch_cnt = r_glitch;
`else
   // No glitch statistics in this build.
`endif

endmodule

// File: tb/tb_hdmi_channel_decode.sv
// Self-checking bench for hdmi_channel_decode (CTRL_RUN_LEN=16,
// DWELL_CYCLES=64, LOSS_TIMEOUT=256). Outputs are compared every cycle
// against a stream-level reference model; the data decode reference is a
// reverse lookup table built by TMDS-encoding every byte in all four modes.

module tb_hdmi_channel_decode;

   localparam int RUN   = 16;
   localparam int DWELL = 64;
   localparam int LOSS  = 256;

   localparam logic [9:0] TOK00 = 10'b1101010100;
   localparam logic [9:0] TOK01 = 10'b0010101011;
   localparam logic [9:0] TOK10 = 10'b0101010100;
   localparam logic [9:0] TOK11 = 10'b1010101011;
   localparam logic [9:0] FILL  = 10'b0000011111;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] word;
   logic [7:0] o_data;
   logic [1:0] o_c;
   logic       o_de;
   logic       o_locked;
   logic [3:0] o_offset;
`ifdef HDMI_DEC_GLITCH_CNT_EN
   logic [15:0] o_glitch_cnt;
`endif

   hdmi_channel_decode #(
      .CTRL_RUN_LEN(RUN),
      .DWELL_CYCLES(DWELL),
      .LOSS_TIMEOUT(LOSS)
   ) dut (
      .i_p_clk     (clk),
      .i_reset     (rst),
      .i_tmds_word (word),
      .o_data      (o_data),
      .o_c         (o_c),
      .o_de        (o_de),
      .o_locked    (o_locked),
      .o_offset    (o_offset)
`ifdef HDMI_DEC_GLITCH_CNT_EN
      ,
      .o_glitch_cnt(o_glitch_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] byte_of [1024];

   // reference model state (stream view)
   int m_prev, m_w1, m_off, m_run, m_dwell, m_loss, m_settle;
   int m_locked, m_data, m_c, m_de, m_glitch, m_h1, m_h2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transmit-side TMDS encoder used only to build the reverse table.
   function automatic logic [9:0] tenc(input logic [7:0] d, input logic xm, input logic inv);
      logic [7:0] q;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xm ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
      return {inv, xm, inv ? ~q : q};
   endfunction

   function automatic int tok_c(input int w);
      if (w == int'(TOK00)) return 0;
      if (w == int'(TOK01)) return 1;
      if (w == int'(TOK10)) return 2;
      if (w == int'(TOK11)) return 3;
      return -1;
   endfunction

   task automatic model_edge(input int w, input logic r);
      int win, c, tk;
      if (r) begin
         m_prev = 0; m_w1 = 0; m_off = 0; m_run = 0; m_dwell = 0; m_loss = 0;
         m_settle = 0; m_locked = 0; m_data = 0; m_c = 0; m_de = 0;
         m_glitch = 0; m_h1 = 0; m_h2 = 0;
      end else begin
         win = (((w << 10) | m_prev) >> m_off) & 1023;
         c   = tok_c(m_w1);
         tk  = (c >= 0) ? 1 : 0;
         if (m_locked == 0) begin
            m_data = 0; m_c = 0; m_de = 0;
            if (tk == 1 && m_settle == 0 && m_run == RUN - 1) begin
               m_locked = 1; m_run = 0; m_dwell = 0; m_loss = 0; m_c = c; m_settle = 0;
            end else if (m_dwell == DWELL - 1) begin
               m_off = (m_off + 1) % 10; m_dwell = 0; m_run = 0; m_settle = 1;
            end else begin
               m_dwell++;
               m_run = (tk == 1 && m_settle == 0) ? m_run + 1 : 0;
               m_settle = 0;
            end
         end else begin
            if (tk == 1 && m_h1 == 0 && m_h2 == 1 && m_glitch < 65535) m_glitch++;
            if (tk == 1) begin
               m_loss = 0; m_de = 0; m_c = c;
            end else if (m_loss == LOSS - 1) begin
               m_locked = 0; m_loss = 0; m_data = 0; m_c = 0; m_de = 0; m_glitch = 0;
            end else begin
               m_loss++; m_de = 1; m_data = int'(byte_of[10'(m_w1)]);
            end
         end
         m_h2 = m_h1; m_h1 = tk; m_prev = w; m_w1 = win;
      end
   endtask

   task automatic apply(input logic [9:0] w, input logic r);
      @(negedge clk);
      word = w;
      rst  = r;
      model_edge(int'(w), r);
      @(posedge clk);
      #1;
      chk("data",   32'(o_data),   m_data);
      chk("c",      32'(o_c),      m_c);
      chk("de",     32'(o_de),     m_de);
      chk("locked", 32'(o_locked), m_locked);
      chk("offset", 32'(o_offset), m_off);
`ifdef HDMI_DEC_GLITCH_CNT_EN
      chk("glitch", 32'(o_glitch_cnt), m_glitch);
`endif
   endtask

   function automatic logic [9:0] rand_data();
      return tenc(8'($urandom), 1'($urandom), 1'($urandom));
   endfunction

   initial begin
      logic [7:0]  dbytes [4];
      logic [19:0] cat;
      logic [9:0]  rot;
      logic [9:0]  tk;
      int          len;

      rst  = 1'b1;
      word = 10'd0;
      for (int b = 0; b < 256; b++)
         for (int m = 0; m < 4; m++)
            byte_of[tenc(8'(b), 1'(m & 1), 1'(m >> 1))] = 8'(b);

      // reset state
      apply(10'd0, 1'b1);
      apply(10'd0, 1'b1);
      chk("rst_data", 32'(o_data), 0);
      chk("rst_c", 32'(o_c), 0);
      chk("rst_de", 32'(o_de), 0);
      chk("rst_locked", 32'(o_locked), 0);
      chk("rst_offset", 32'(o_offset), 0);

      // aligned tokens: lock after 16 tokens + 2 cycles
      for (int k = 1; k <= 20; k++) begin
         apply(TOK00, 1'b0);
         if (k == 17) chk("lock_early", 32'(o_locked), 0);
         if (k == 18) begin
            chk("lock_at18", 32'(o_locked), 1);
            chk("lock_off", 32'(o_offset), 0);
            chk("lock_c", 32'(o_c), 0);
            chk("lock_de", 32'(o_de), 0);
         end
      end

      // directed data bytes
      dbytes[0] = 8'h00; dbytes[1] = 8'hFF; dbytes[2] = 8'hA5; dbytes[3] = 8'h10;
      for (int i = 0; i < 4; i++) begin
         apply(tenc(dbytes[i], 1'b1, 1'b0), 1'b0);
         apply(TOK00, 1'b0);
         apply(TOK00, 1'b0);
         chk("dir_data", 32'(o_data), 32'(dbytes[i]));
         chk("dir_de", 32'(o_de), 1);
      end

      // random mix of tokens and data while locked
      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0: tk = TOK00;
               1: tk = TOK01;
               2: tk = TOK10;
               default: tk = TOK11;
            endcase
            apply(tk, 1'b0);
         end else begin
            apply(rand_data(), 1'b0);
         end
      end

      // sync recovery: alternating 01 / 11 runs with data between
      for (int r = 0; r < 4; r++) begin
         tk  = (r % 2 == 1) ? TOK11 : TOK01;
         len = $urandom_range(3, 8);
         for (int k = 0; k < len; k++) apply(tk, 1'b0);
         chk("sync_c", 32'(o_c), (r % 2 == 1) ? 3 : 1);
         chk("sync_de", 32'(o_de), 0);
         len = $urandom_range(2, 6);
         for (int k = 0; k < len; k++) apply(rand_data(), 1'b0);
      end

      // loss of lock after LOSS non-token words
      for (int k = 0; k < 4; k++) apply(TOK00, 1'b0);
      for (int k = 1; k <= 258; k++) begin
         apply(FILL, 1'b0);
         if (k == 257) chk("loss_hold", 32'(o_locked), 1);
         if (k == 258) begin
            chk("loss_drop", 32'(o_locked), 0);
            chk("loss_off", 32'(o_offset), 0);
         end
      end

      // lock-qualifying token coincides with dwell expiry
      apply(10'd0, 1'b1);
      for (int k = 1; k <= 46; k++) apply(FILL, 1'b0);
      for (int k = 47; k <= 66; k++) begin
         apply(TOK00, 1'b0);
         if (k == 63) chk("race_pre", 32'(o_locked), 0);
         if (k == 64) begin
            chk("race_lock", 32'(o_locked), 1);
            chk("race_off", 32'(o_offset), 0);
         end
      end

      // misaligned stream: tokens at true offset 7
      apply(10'd0, 1'b1);
      cat = {TOK00, TOK00};
      rot = cat[12:3];
      for (int k = 0; k < 1000; k++) begin
         if (o_locked) break;
         apply(rot, 1'b0);
      end
      chk("rot_lock", 32'(o_locked), 1);
      chk("rot_off", 32'(o_offset), 7);
      for (int k = 0; k < 5; k++) apply(rot, 1'b0);

      // offset wrap 9 -> 0 on random data
      apply(10'd0, 1'b1);
      for (int k = 1; k <= 645; k++) begin
         apply(10'($urandom), 1'b0);
         if (k == 639) chk("wrap_9", 32'(o_offset), 9);
         if (k == 640) chk("wrap_0", 32'(o_offset), 0);
      end

      // isolated glitches, then reset mid-lock
      apply(10'd0, 1'b1);
      for (int k = 0; k < 20; k++) apply(TOK00, 1'b0);
      for (int k = 0; k < 3; k++) begin
         apply(FILL, 1'b0);
         apply(TOK00, 1'b0);
      end
      apply(TOK00, 1'b0);
      apply(TOK00, 1'b0);
      chk("glitch_locked", 32'(o_locked), 1);
`ifdef HDMI_DEC_GLITCH_CNT_EN
      chk("glitch_cnt3", 32'(o_glitch_cnt), 3);
`endif
      apply(TOK00, 1'b1);
      chk("mid_rst_locked", 32'(o_locked), 0);
      chk("mid_rst_c", 32'(o_c), 0);
      chk("mid_rst_data", 32'(o_data), 0);
      chk("mid_rst_de", 32'(o_de), 0);
      chk("mid_rst_off", 32'(o_offset), 0);
`ifdef HDMI_DEC_GLITCH_CNT_EN
      chk("mid_rst_glitch", 32'(o_glitch_cnt), 0);
`endif
      apply(TOK00, 1'b0);
      chk("post_rst_locked", 32'(o_locked), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
